// File: rtl/a1_step_seq.sv
// a1_step_seq: A1 pointer-stepping sequencer.
// Owns the A1 X/Y pointer, drives the external address adder operands and
// captures its result back into the pointer. It walks an inner pixel loop
// nested inside an outer line loop and offers each pointer position to the
// pixel pipeline.
//
// Handshake: pix_req is high while a pointer position is offered and
// ptr_x/ptr_y are stable for as long as pix_req stays high. A position is
// transferred on a rising edge where pix_req and pix_ack are both 1. pix_ack
// has no effect at any other time.
module a1_step_seq #(
    parameter int W  = 16,
    parameter int CW = 16
) (
    input  logic          sys_clk,
    input  logic          resetl,
    input  logic          start,
    input  logic          ld_ptr,
    input  logic [W-1:0]  ptr_x_in,
    input  logic [W-1:0]  ptr_y_in,
    input  logic [CW-1:0] inner_cnt,
    input  logic [CW-1:0] outer_cnt,
    input  logic [W-1:0]  inc_x,
    input  logic [W-1:0]  inc_y,
    input  logic          inc_x_neg,
    input  logic          inc_y_neg,
    input  logic [W-1:0]  step_x,
    input  logic [W-1:0]  step_y,
    input  logic          step_x_neg,
    input  logic          step_y_neg,
    input  logic [2:0]    modx_cfg,
    output logic [W-1:0]  adda_x,
    output logic [W-1:0]  adda_y,
    output logic [W-1:0]  addb_x,
    output logic [W-1:0]  addb_y,
    output logic          suba_x,
    output logic          suba_y,
    output logic [2:0]    modx,
    input  logic [W-1:0]  addq_x,
    input  logic [W-1:0]  addq_y,
    output logic          pix_req,
    input  logic          pix_ack,
    output logic [W-1:0]  ptr_x,
    output logic [W-1:0]  ptr_y,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PIXEL = 3'd1,
        S_INC   = 3'd2,
        S_STEP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [CW-1:0] inner_rem;   // pixels still to issue on the current line
    logic [CW-1:0] outer_rem;   // lines still to issue, including the current one
    logic [CW-1:0] inner_lat;   // pixels per line, used to reload inner_rem

    logic          start_go;    // start accepted with both counts non-zero
    logic          start_zero;  // start accepted but one count is zero
    logic          px_ack;      // pixel handed over this cycle
    logic          more_inner;
    logic          more_outer;

    assign start_go   = (state == S_IDLE) && start &&
                        (inner_cnt != '0) && (outer_cnt != '0);
    assign start_zero = (state == S_IDLE) && start && !start_go;
    assign px_ack     = (state == S_PIXEL) && pix_ack;
    assign more_inner = (inner_rem > CW'(1));
    assign more_outer = (outer_rem > CW'(1));

    // State register
    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one PIXEL visit per position, INC between pixels of
    // a line, STEP between lines, DONE once the last pixel is accepted.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_go) begin
                    state_nxt = S_PIXEL;
                end else if (start_zero) begin
                    state_nxt = S_DONE;
                end
            end
            S_PIXEL: begin
                if (pix_ack) begin
                    if (more_inner) begin
                        state_nxt = S_INC;
                    end else if (more_outer) begin
                        state_nxt = S_STEP;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_INC:   state_nxt = S_PIXEL;
            S_STEP:  state_nxt = S_PIXEL;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Adder operand selection and status outputs decoded from the state
    always_comb begin
        adda_x  = ptr_x;
        adda_y  = ptr_y;
        addb_x  = '0;
        addb_y  = '0;
        suba_x  = 1'b0;
        suba_y  = 1'b0;
        pix_req = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_PIXEL: begin
                pix_req = 1'b1;
            end
            S_INC: begin
                addb_x = inc_x;
                addb_y = inc_y;
                suba_x = inc_x_neg;
                suba_y = inc_y_neg;
            end
            S_STEP: begin
                addb_x = step_x;
                addb_y = step_y;
                suba_x = step_x_neg;
                suba_y = step_y_neg;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // Pointer register: loaded from the inputs while idle, otherwise only
    // updated with the adder result during INC/STEP.
    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            ptr_x <= '0;
            ptr_y <= '0;
        end else if ((state == S_IDLE) && ld_ptr) begin
            ptr_x <= ptr_x_in;
            ptr_y <= ptr_y_in;
        end else if ((state == S_INC) || (state == S_STEP)) begin
            ptr_x <= addq_x;
            ptr_y <= addq_y;
        end
    end

    // Loop counters and modulo code: latched at start, counted down on acks
    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            inner_rem <= '0;
            outer_rem <= '0;
            inner_lat <= '0;
            modx      <= '0;
        end else if ((state == S_IDLE) && start) begin
            inner_rem <= inner_cnt;
            outer_rem <= outer_cnt;
            inner_lat <= inner_cnt;
            modx      <= modx_cfg;
        end else if (px_ack) begin
            if (more_inner) begin
                inner_rem <= inner_rem - CW'(1);
            end else if (more_outer) begin
                outer_rem <= outer_rem - CW'(1);
                inner_rem <= inner_lat;
            end
        end
    end

endmodule
